// File: rtl/bus_frame_pkg.sv
// bus_frame_pkg: beat numbering, phase type and defaults for the byte-serial bus frame
package bus_frame_pkg;
  typedef logic [3:0] phase_t;
  localparam phase_t BEAT_IDLE = 4'd0;
  localparam phase_t BEAT_A0 = 4'd1;
  localparam phase_t BEAT_A1 = 4'd2;
  localparam phase_t BEAT_A2 = 4'd3;
  localparam phase_t BEAT_A3 = 4'd4;
  localparam phase_t BEAT_CTL = 4'd5;
  localparam phase_t BEAT_ACC = 4'd6;
  localparam phase_t BEAT_CAP = 4'd7;
  localparam phase_t BEAT_R0 = 4'd8;
  localparam phase_t BEAT_R1 = 4'd9;
  localparam phase_t BEAT_R2 = 4'd10;
  localparam phase_t BEAT_R3 = 4'd11;
  localparam phase_t BEAT_LAST = 4'd11;
  localparam bit WRITE_POL_DEF = 1'b1;
endpackage

// File: rtl/frame_byte_gather.sv
// frame_byte_gather: 4x8 byte-lane register written one lane per cycle
module frame_byte_gather (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  lane,
  input  logic [7:0]  din,
  output logic [31:0] q
);
  logic [31:0] lanes_q, lanes_d;
  always_comb begin
    lanes_d = lanes_q;
    if (we) lanes_d[{lane, 3'b000} +: 8] = din;
  end
  always_ff @(posedge clk) lanes_q <= rst ? '0 : lanes_d;
  assign q = lanes_q;
endmodule

// File: rtl/bus_frame_responder.sv
// bus_frame_responder: memory-side byte-serial frame deserializer, access strobe and read serializer
module bus_frame_responder
  import bus_frame_pkg::*;
#(
  parameter bit WRITE_POL = WRITE_POL_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_sync,
  input  logic [7:0]  addr_in,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        abort
);
  phase_t ph_q, ph_d, cur;
  logic mem_en_q, mem_en_d, mem_we_q, mem_we_d, abort_q, abort_d, data_oe_q, data_oe_d, gather;
  logic [7:0] data_out_q, data_out_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [1:0] lane;
  always_comb begin
    cur = frame_sync ? BEAT_A0 : ph_q;
    ph_d = (cur == BEAT_IDLE || cur == BEAT_LAST) ? BEAT_IDLE : phase_t'(cur + 4'd1);
    gather = cur >= BEAT_A0 && cur <= BEAT_A3;
    lane = cur[1:0] - 2'd1;
    mem_en_d = cur == BEAT_CTL;
    mem_we_d = cur == BEAT_CTL ? addr_in[0] == WRITE_POL : mem_we_q;
    rbuf_d = (cur == BEAT_CAP && !mem_we_q) ? mem_rdata : rbuf_q;
    data_oe_d = ph_d >= BEAT_R0 && !mem_we_q;
    data_out_d = data_oe_d ? rbuf_d[{ph_d[1:0], 3'b000} +: 8] : 8'd0;
    abort_d = frame_sync && ph_q >= BEAT_A1 && ph_q < BEAT_LAST;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q <= BEAT_IDLE;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      abort_q <= 1'b0;
      data_oe_q <= 1'b0;
      data_out_q <= '0;
      rbuf_q <= '0;
    end else begin
      ph_q <= ph_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      abort_q <= abort_d;
      data_oe_q <= data_oe_d;
      data_out_q <= data_out_d;
      rbuf_q <= rbuf_d;
    end
  end
  frame_byte_gather u_addr (.clk(clk), .rst(rst), .we(gather), .lane(lane), .din(addr_in), .q(mem_addr));
  frame_byte_gather u_wdata (.clk(clk), .rst(rst), .we(gather), .lane(lane), .din(data_in), .q(mem_wdata));
  assign busy = ph_q != BEAT_IDLE;
  assign abort = abort_q;
  assign mem_en = mem_en_q;
  assign mem_we = mem_we_q;
  assign data_oe = data_oe_q;
  assign data_out = data_out_q;
endmodule
